// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: compares the last WIDTH accepted bits against a live pattern.
// Optional saturating match counter is built only when PATTERN_DET_COUNT_EN is defined.
module pattern_detector #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic [WIDTH-1:0] pattern,
  input  logic             overlap,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned FillW = $clog2(WIDTH + 1);
  localparam logic [FillW-1:0] FullFill = FillW'(WIDTH);

  localparam logic StFill  = 1'b0;
  localparam logic StArmed = 1'b1;

  logic [WIDTH-1:0] window_q, window_d, window_n;
  logic [FillW-1:0] fill_q, fill_d, fill_n;
  logic             state_q, state_d;
  logic             out_q, out_d;
  logic             match;

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    state_d  = state_q;
    out_d    = 1'b0;
    match    = 1'b0;
    window_n = {window_q[WIDTH-2:0], in};
    fill_n   = (state_q == StArmed) ? FullFill : fill_q + 1'b1;

    if (clear) begin
      window_d = '0;
      fill_d   = '0;
      state_d  = StFill;
    end else if (in_valid) begin
      match = (fill_n == FullFill) && (window_n == pattern);
      out_d = match;
      if (match && !overlap) begin
        // Non-overlapping: the next match must be built from WIDTH fresh bits.
        window_d = '0;
        fill_d   = '0;
        state_d  = StFill;
      end else begin
        window_d = window_n;
        fill_d   = fill_n;
        state_d  = (fill_n == FullFill) ? StArmed : StFill;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window_q <= '0;
      fill_q   <= '0;
      state_q  <= StFill;
      out_q    <= 1'b0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

`ifdef PATTERN_DET_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (match && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Directed table-driven bench for pattern_detector, plus saturation and async-reset sequences.
module tb_pattern_detector;

`ifdef PATTERN_DET_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic [3:0] pattern = 4'b1011;
  logic       overlap = 1'b1;
  logic       clear = 1'b0;
  logic       out, out_sat;
  logic [7:0] count;
  logic [1:0] count_sat;

  int tests = 0;
  int fails = 0;

  pattern_detector #(.WIDTH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in       (in_bit),
    .pattern  (pattern),
    .overlap  (overlap),
    .clear    (clear),
    .out      (out),
    .count    (count)
  );

  pattern_detector #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in       (in_bit),
    .pattern  (pattern),
    .overlap  (overlap),
    .clear    (clear),
    .out      (out_sat),
    .count    (count_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       vld;
    logic       b;
    logic [3:0] pat;
    logic       ovl;
    logic       exp_out;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic clr, logic vld, logic b, logic [3:0] pat, logic ovl,
                              logic eo, int ec);
    vec_t v;
    v.clr = clr; v.vld = vld; v.b = b; v.pat = pat; v.ovl = ovl;
    v.exp_out = eo; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(logic clr, logic vld, logic b);
    clear    = clr;
    in_valid = vld;
    in_bit   = b;
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_exp(int c, int maxv);
    if (!CntEn) return 0;
    return (c > maxv) ? maxv : c;
  endfunction

  initial begin
    int pulses;

    // Overlapping, pattern 1011: 1,0,1,1,0,1,1 -> pulses after bits 4 and 7
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 4'b1011, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 1, 2));
    vecs.push_back(mk(1, 0, 0, 4'b1011, 1, 0, 0));
    // Non-overlapping: same stimulus, only one pulse
    vecs.push_back(mk(0, 1, 1, 4'b1011, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1011, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 4'b1011, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'b1011, 0, 0, 0));
    // Gaps between every bit; discarded in=1 during gaps
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 4'b1011, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'b1011, 1, 0, 0));
    // Clear collides with the match-completing bit; a fresh 1,0,1,1 is needed
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 4'b1011, 1, 0, 0));
    // Live pattern change keeps history: 1,0,1 then pattern 1010 with bit 0
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1010, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 4'b1010, 1, 0, 0));

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("reset_out", int'(out), 0);
    check("reset_count", int'(count), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (vecs[i]) begin
      pattern = vecs[i].pat;
      overlap = vecs[i].ovl;
      step(vecs[i].clr, vecs[i].vld, vecs[i].b);
      check($sformatf("vec%0d_out", i), int'(out), int'(vecs[i].exp_out));
      check($sformatf("vec%0d_out_sat", i), int'(out_sat), int'(vecs[i].exp_out));
      check($sformatf("vec%0d_count", i), int'(count), cnt_exp(vecs[i].exp_cnt, 255));
      check($sformatf("vec%0d_count_sat", i), int'(count_sat), cnt_exp(vecs[i].exp_cnt, 3));
    end

    // Saturation: ten 1s against 1111, overlapping -> 7 pulses, 2-bit count holds at 3
    pattern = 4'b1111;
    overlap = 1'b1;
    step(1, 0, 0);
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step(0, 1, 1);
      if (out_sat) pulses++;
      check($sformatf("sat_out_%0d", k), int'(out_sat), (k >= 4) ? 1 : 0);
      check($sformatf("sat_count_%0d", k), int'(count_sat), cnt_exp((k >= 4) ? k - 3 : 0, 3));
    end
    check("sat_pulses", pulses, 7);
    check("sat_wide_count", int'(count), cnt_exp(7, 255));
    step(0, 0, 0);
    check("sat_out_after", int'(out_sat), 0);

    // Async reset mid-cycle while out is high and count is nonzero
    pattern = 4'b1011;
    step(1, 0, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    check("pre_rst_out", int'(out), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out", int'(out), 0);
    check("async_rst_count", int'(count), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(0, 1, 1);
    check("post_rst_b1_out", int'(out), 0);
    step(0, 1, 1);
    check("post_rst_b2_out", int'(out), 0);
    check("post_rst_count", int'(count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
